// File: rtl/preg_reclaim.sv
// rtl/preg_reclaim.sv - retire-side reclaim queue returning old physical registers to the freelist
// Two-wide compacting circular queue, one-cycle latency, sticky overflow on stalled retire.
module preg_reclaim #(
  parameter  int NUM_PREGS = 64,
  parameter  int DEPTH     = 8,
  localparam int PW        = $clog2(NUM_PREGS),
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prev_valid,
  input  logic          retire_has_dest_1,
  input  logic          retire_has_dest_2,
  input  logic [PW-1:0] retire_old_preg_1,
  input  logic [PW-1:0] retire_old_preg_2,
  output logic          stalled,
  output logic          free_valid_1,
  output logic          free_valid_2,
  output logic [PW-1:0] free_preg_1,
  output logic [PW-1:0] free_preg_2,
  input  logic          free_ready,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] space;
  logic          enq_fire;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;

  always_comb begin
    space        = CW'(DEPTH) - count_q;
    stalled      = (space < CW'(2));
    free_valid_1 = (count_q >= CW'(1));
    free_valid_2 = (count_q >= CW'(2));
    free_preg_1  = mem_q[head_q];
    free_preg_2  = mem_q[head_q + AW'(1)];

    enq_fire = prev_valid & ~stalled;
    enq_n    = enq_fire ? ({1'b0, retire_has_dest_1} + {1'b0, retire_has_dest_2}) : 2'd0;
    deq_n    = free_ready ? ({1'b0, free_valid_1} + {1'b0, free_valid_2}) : 2'd0;

    // Slot 2 lands at tail when slot 1 has nothing to free, keeping the queue dense.
    mem_d = mem_q;
    if (enq_fire && retire_has_dest_1)
      mem_d[tail_q] = retire_old_preg_1;
    if (enq_fire && retire_has_dest_2)
      mem_d[retire_has_dest_1 ? (tail_q + AW'(1)) : tail_q] = retire_old_preg_2;

    tail_d     = tail_q + AW'(enq_n);
    head_d     = head_q + AW'(deq_n);
    count_d    = count_q + CW'(enq_n) - CW'(deq_n);
    overflow_d = overflow_q | (prev_valid & stalled);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Contents survive reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
